// File: rtl/mlp_xor_sequencer.sv
// XOR-dataset sequencer for a small MLP: trains on four samples, evaluates them,
// then scores delayed predictions against the target class once per epoch.
package common_pkg;
  typedef logic signed [15:0] sfp;
  typedef sfp [1:0] sfp2;
  localparam sfp ONE  = 16'sh0100;
  localparam sfp HALF = 16'sh0080;
endpackage

module mlp_xor_sequencer
  import common_pkg::*;
#(
  parameter int EPOCHS   = 100,
  parameter int PRED_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  sfp          threshold,
  input  sfp          prediction,
  output sfp  [1:0]   values,
  output sfp  [0:0]   expected,
  output logic        training,
  output logic        busy,
  output logic        done,
  output logic [15:0] epoch,
  output logic [2:0]  epoch_correct,
  output logic        correct_valid
);

  typedef enum logic [2:0] {IDLE, TRAIN, EVAL, DRAIN, DONE} state_t;

  state_t              state;
  logic [1:0]          s;
  logic [1:0]          dcnt;
  logic [PRED_LAT-1:0] vld_pipe;
  logic [PRED_LAT-1:0] cls_pipe;
  logic [2:0]          acc;
  logic [2:0]          acc_nxt;
  logic [1:0]          ncmp;
  logic                hit;

  function automatic sfp2 vec_of(logic [1:0] i);
    sfp2 v;
    v[0] = i[1] ? ONE : '0;
    v[1] = i[0] ? ONE : '0;
    return v;
  endfunction

  function automatic sfp exp_of(logic [1:0] i);
    return (i[1] ^ i[0]) ? ONE : '0;
  endfunction

  // Outputs are loaded together with the state they belong to, so values/expected
  // always describe the sample of the current cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s           <= '0;
      dcnt        <= '0;
      values      <= '0;
      expected    <= '0;
      training    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      epoch       <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state       <= TRAIN;
          s           <= '0;
          epoch       <= '0;
          training    <= 1'b1;
          busy        <= 1'b1;
          done        <= 1'b0;
          values      <= vec_of(2'd0);
          expected[0] <= exp_of(2'd0);
        end
        TRAIN: begin
          s           <= s + 2'd1;
          values      <= vec_of(s + 2'd1);
          expected[0] <= exp_of(s + 2'd1);
          if (s == 2'd3) begin
            state    <= EVAL;
            training <= 1'b0;
          end
        end
        EVAL: begin
          s <= s + 2'd1;
          if (s == 2'd3) begin
            state    <= DRAIN;
            dcnt     <= '0;
            values   <= '0;
            expected <= '0;
          end else begin
            values      <= vec_of(s + 2'd1);
            expected[0] <= exp_of(s + 2'd1);
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'(PRED_LAT - 1)) begin
            if (epoch == 16'(EPOCHS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state       <= TRAIN;
              epoch       <= epoch + 16'd1;
              s           <= '0;
              training    <= 1'b1;
              values      <= vec_of(2'd0);
              expected[0] <= exp_of(2'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hit     = vld_pipe[PRED_LAT-1] &&
                   ((prediction < threshold) == cls_pipe[PRED_LAT-1]);
  assign acc_nxt = (hit && acc != 3'd4) ? acc + 3'd1 : acc;

  // The class bit is taken with the threshold seen at issue time; the prediction
  // side uses the threshold seen when it returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe      <= '0;
      cls_pipe      <= '0;
      acc           <= '0;
      ncmp          <= '0;
      epoch_correct <= '0;
      correct_valid <= 1'b0;
    end else begin
      correct_valid <= 1'b0;
      vld_pipe[0]   <= (state == EVAL);
      cls_pipe[0]   <= ($signed(expected[0]) < threshold);
      for (int i = 1; i < PRED_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        cls_pipe[i] <= cls_pipe[i-1];
      end
      if (state == TRAIN && s == 2'd3) begin
        acc  <= '0;
        ncmp <= '0;
      end else if (vld_pipe[PRED_LAT-1]) begin
        acc  <= acc_nxt;
        ncmp <= ncmp + 2'd1;
        if (ncmp == 2'd3) begin
          epoch_correct <= acc_nxt;
          correct_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_xor_sequencer.sv
// Directed bench: two sequencer instances (PRED_LAT 1 and 3) driven by an MLP stub,
// per-epoch scores checked through a scoreboard queue.
module tb_mlp_xor_sequencer;
  import common_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start3 = 1'b0;
  sfp          threshold = HALF;
  sfp          pred1 = '0, pred3 = '0, p3a = '0, p3b = '0;
  sfp  [1:0]   val1, val3;
  sfp  [0:0]   ex1, ex3;
  logic        tr1, tr3, busy1, busy3, done1, done3, cv1, cv3;
  logic [15:0] ep1, ep3;
  logic [2:0]  ec1, ec3;
  int          mode = 0;

  int checks = 0, errors = 0;
  int sbq1[$], sbq3[$];

  mlp_xor_sequencer #(.EPOCHS(2), .PRED_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .threshold(threshold), .prediction(pred1),
    .values(val1), .expected(ex1), .training(tr1), .busy(busy1), .done(done1),
    .epoch(ep1), .epoch_correct(ec1), .correct_valid(cv1));

  mlp_xor_sequencer #(.EPOCHS(2), .PRED_LAT(3)) u_lat (
    .clk(clk), .rst(rst), .start(start3), .threshold(threshold), .prediction(pred3),
    .values(val3), .expected(ex3), .training(tr3), .busy(busy3), .done(done3),
    .epoch(ep3), .epoch_correct(ec3), .correct_valid(cv3));

  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // MLP stub: 0 perfect, 1 inverted, 2 equal to threshold, 3 negative,
  // 4 correct on training samples but wrong on evaluation samples.
  function automatic sfp stub(sfp e, logic tr, int m, sfp thr);
    case (m)
      0:       return e;
      1:       return ONE - e;
      2:       return thr;
      3:       return -ONE;
      default: return tr ? e : ONE - e;
    endcase
  endfunction

  always @(posedge clk) begin
    pred1 <= stub(ex1[0], tr1, mode, threshold);
    p3a   <= stub(ex3[0], tr3, mode, threshold);
    p3b   <= p3a;
    pred3 <= p3b;
  end

  function automatic int model_cnt(int m, sfp thr);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      sfp e, p;
      e = ((((i >> 1) ^ i) & 1) != 0) ? ONE : sfp'(0);
      p = stub(e, 1'b0, m, thr);
      if ((p < thr) == (e < thr)) n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (cv1) begin
      if (sbq1.size() == 0) chk("cv1_extra", 1, 0);
      else chk("ecorr1", int'(ec1), sbq1.pop_front());
    end
    if (cv3) begin
      if (sbq3.size() == 0) chk("cv3_extra", 1, 0);
      else chk("ecorr3", int'(ec3), sbq3.pop_front());
    end
  end

  task automatic chk_zero1(string tag);
    chk({tag, "_v0"}, int'(val1[0]), 0);
    chk({tag, "_v1"}, int'(val1[1]), 0);
    chk({tag, "_ex"}, int'(ex1[0]), 0);
    chk({tag, "_tr"}, int'(tr1), 0);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_ep"}, int'(ep1), 0);
    chk({tag, "_ec"}, int'(ec1), 0);
    chk({tag, "_cv"}, int'(cv1), 0);
  endtask

  // One run on the PRED_LAT=1 instance; cycle k is the one after the k-th edge
  // counted from the accept edge. poke_k pulses start while busy, rst_k aborts.
  task automatic run1(int m, int poke_k, int rst_k);
    for (int e = 0; e < 2; e++) sbq1.push_back(model_cnt(m, threshold));
    mode = m;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      int p, s, v0, v1, ex;
      bit act;
      @(negedge clk);
      if (k == rst_k) begin
        #1 rst = 1'b1;
        #1 chk_zero1("rst_mid");
        sbq1.delete();
        @(negedge clk); rst = 1'b0;
        return;
      end
      p   = k % 9;
      s   = p % 4;
      act = (k < 18) && (p < 8);
      v0  = (act && s >= 2) ? 256 : 0;
      v1  = (act && (s % 2) == 1) ? 256 : 0;
      ex  = (act && ((s >= 2) != ((s % 2) == 1))) ? 256 : 0;
      chk("train", int'(tr1), (k < 18 && p < 4) ? 1 : 0);
      chk("val0", int'(val1[0]), v0);
      chk("val1", int'(val1[1]), v1);
      chk("exp", int'(ex1[0]), ex);
      chk("busy", int'(busy1), (k < 18) ? 1 : 0);
      chk("done", int'(done1), (k == 18) ? 1 : 0);
      chk("epoch", int'(ep1), (k < 18) ? k / 9 : 1);
      if (k == poke_k) begin
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
      end
    end
  endtask

  task automatic run3(int m);
    for (int e = 0; e < 2; e++) sbq3.push_back(model_cnt(m, threshold));
    mode = m;
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      chk("busy3", int'(busy3), (k < 22) ? 1 : 0);
      chk("done3", int'(done3), (k == 22) ? 1 : 0);
      chk("train3", int'(tr3), (k < 22 && (k % 11) < 4) ? 1 : 0);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #2 chk_zero1("rst");
    start1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("busy_in_rst", int'(busy1), 0);
    @(negedge clk); rst = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge clk);

    run1(0, -1, -1);   // sequence + perfect model
    run1(1, -1, -1);   // inverted model
    run1(2, -1, -1);   // prediction == threshold
    run1(3, -1, -1);   // negative prediction
    run3(4);           // deep latency, training leakage must not count
    run1(0, -1, 14);   // reset in epoch 1 EVAL
    run1(0, 10, -1);   // restart from epoch 0, start poked while busy

    repeat (3) @(negedge clk);
    chk("sb1_left", sbq1.size(), 0);
    chk("sb3_left", sbq3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
